// File: rtl/pwm_pkg.sv
// Shared widths, FSM state type and duty-ramp helper for pwm_cfg_sequencer.
// Build option: PWM_CFG_SOFT_RAMP_EN adds the RAMP_WAIT state (soft duty ramp).
package pwm_pkg;

    localparam int unsigned PERIOD_W     = 12;
    localparam int unsigned DUTY_W       = 7;
    localparam int unsigned DUTY_MAX_DEF = 99;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WR_PERIOD = 2'd1,
`ifdef PWM_CFG_SOFT_RAMP_EN
        WR_DUTY   = 2'd2,
        RAMP_WAIT = 2'd3
`else
        WR_DUTY   = 2'd2
`endif
    } state_t;

    // Move cur one step toward tgt without overshooting it.
    function automatic logic [DUTY_W-1:0] ramp_next(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W-1:0] step
    );
        logic [DUTY_W-1:0] gap;
        if (tgt >= cur) begin
            gap       = tgt - cur;
            ramp_next = (gap > step) ? cur + step : tgt;
        end else begin
            gap       = cur - tgt;
            ramp_next = (gap > step) ? cur - step : tgt;
        end
    endfunction

endpackage

// File: rtl/pwm_ramp_timer.sv
// Down-counter spacing soft-ramp duty writes: start loads RAMP_DIV, tick marks
// the last wait cycle so the next write lands RAMP_DIV+1 cycles after the previous.
module pwm_ramp_timer #(
    parameter int unsigned RAMP_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(RAMP_DIV + 1);

    logic [CNT_W-1:0] cnt;

    // Load on start, count down to zero and park there.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CNT_W'(RAMP_DIV);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_W'(1));

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// Validates {period, duty} requests and sequences them into the PWM generator's
// shared write port (period first, then duty); owns the generator's out_en.
// Build option: PWM_CFG_SOFT_RAMP_EN ramps duty in RAMP_STEP increments,
// RAMP_DIV cycles apart, instead of writing the target at once.
module pwm_cfg_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned DUTY_MAX  = DUTY_MAX_DEF,
    parameter int unsigned RAMP_STEP = 1,
    parameter int unsigned RAMP_DIV  = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [DUTY_W-1:0]   cfg_duty,
    input  logic                run,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic                busy,
    output logic [PERIOD_W-1:0] pwm_in,
    output logic                pwm_sel,
    output logic                pwm_wr_en,
    output logic                pwm_out_en
);

    localparam logic [DUTY_W-1:0] DUTY_MAX_L = DUTY_W'(DUTY_MAX);

    if (RAMP_STEP == 0 || RAMP_DIV == 0) begin : g_param_check
        $error("pwm_cfg_sequencer: RAMP_STEP and RAMP_DIV must be >= 1");
    end

    state_t              state;
    logic [PERIOD_W-1:0] cur_period;
    logic [DUTY_W-1:0]   cur_duty;
    logic                configured;

    logic                accept;
    logic                req_ok;
    logic                take;
    logic                issue_period;
    logic                issue_duty;
    logic                ramp_more;
    logic                next_idle;
    logic [DUTY_W-1:0]   duty_wr;
    logic                done_now;

    assign accept = cfg_valid && cfg_ready && (state == IDLE);
    assign req_ok = (cfg_period != '0) && (cfg_duty != '0) && (cfg_duty <= DUTY_MAX_L);
    assign take   = accept && req_ok;

`ifdef PWM_CFG_SOFT_RAMP_EN
    localparam logic [DUTY_W-1:0] STEP_L = DUTY_W'(RAMP_STEP);

    logic [DUTY_W-1:0] tgt_duty;
    logic [DUTY_W-1:0] target_sel;
    logic              ramp_tick;

    pwm_ramp_timer #(
        .RAMP_DIV (RAMP_DIV)
    ) u_ramp_timer (
        .clk   (clk),
        .rst   (rst),
        .start (ramp_more),
        .tick  (ramp_tick)
    );

    // Target comes straight from the request on the period-skip path.
    assign target_sel = (state == IDLE) ? cfg_duty : tgt_duty;
    assign duty_wr    = ramp_next(cur_duty, target_sel, STEP_L);
    assign done_now   = (duty_wr == target_sel);
    assign ramp_more  = (state == WR_DUTY) && (cur_duty != tgt_duty);
    assign issue_duty = (take && (cfg_period == cur_period)) ||
                        (state == WR_PERIOD) ||
                        ((state == RAMP_WAIT) && ramp_tick);
`else
    // cur_duty is loaded at acceptance, so it already holds the target when
    // WR_PERIOD issues the duty write.
    assign duty_wr    = (state == IDLE) ? cfg_duty : cur_duty;
    assign done_now   = 1'b1;
    assign ramp_more  = 1'b0;
    assign issue_duty = (take && (cfg_period == cur_period)) || (state == WR_PERIOD);
`endif

    assign issue_period = take && (cfg_period != cur_period);
    assign next_idle    = ((state == IDLE) && !take) || ((state == WR_DUTY) && !ramp_more);

    // Sequencer FSM with registered handshake and write-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_period <= '0;
            cur_duty   <= '0;
            configured <= 1'b0;
            cfg_ready  <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            busy       <= 1'b0;
            pwm_in     <= '0;
            pwm_sel    <= 1'b0;
            pwm_wr_en  <= 1'b0;
            pwm_out_en <= 1'b0;
`ifdef PWM_CFG_SOFT_RAMP_EN
            tgt_duty   <= '0;
`endif
        end else begin
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            pwm_wr_en  <= 1'b0;
            pwm_out_en <= run && configured;
            cfg_ready  <= next_idle;
            busy       <= !next_idle;

            if (accept && !req_ok) begin
                cfg_err <= 1'b1;
            end

            if (take) begin
`ifdef PWM_CFG_SOFT_RAMP_EN
                tgt_duty <= cfg_duty;
`else
                cur_duty <= cfg_duty;
`endif
            end

            if (issue_period) begin
                state      <= WR_PERIOD;
                pwm_sel    <= 1'b1;
                pwm_wr_en  <= 1'b1;
                pwm_in     <= cfg_period;
                cur_period <= cfg_period;
            end else if (issue_duty) begin
                state      <= WR_DUTY;
                pwm_sel    <= 1'b0;
                pwm_wr_en  <= 1'b1;
                pwm_in     <= {{(PERIOD_W - DUTY_W){1'b0}}, duty_wr};
                cur_duty   <= duty_wr;
                configured <= 1'b1;
                cfg_done   <= done_now;
            end else if (state == WR_DUTY) begin
`ifdef PWM_CFG_SOFT_RAMP_EN
                state <= ramp_more ? RAMP_WAIT : IDLE;
`else
                state <= IDLE;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Directed self-checking bench for pwm_cfg_sequencer.
// Build option: PWM_CFG_SOFT_RAMP_EN selects the soft-ramp scenario set.
module tb_pwm_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [11:0] cfg_period;
    logic [6:0]  cfg_duty;
    logic        run;
    logic        cfg_done;
    logic        cfg_err;
    logic        busy;
    logic [11:0] pwm_in;
    logic        pwm_sel;
    logic        pwm_wr_en;
    logic        pwm_out_en;

    int checks = 0;
    int errors = 0;

    // flags = {ready, done, err, busy, out_en, sel, wr_en}
    logic [18:0] obs;
    logic [18:0] exp_v;
    assign obs = {cfg_ready, cfg_done, cfg_err, busy, pwm_out_en, pwm_sel, pwm_wr_en, pwm_in};

    pwm_cfg_sequencer #(
        .DUTY_MAX  (99),
        .RAMP_STEP (10),
        .RAMP_DIV  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .run        (run),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .busy       (busy),
        .pwm_in     (pwm_in),
        .pwm_sel    (pwm_sel),
        .pwm_wr_en  (pwm_wr_en),
        .pwm_out_en (pwm_out_en)
    );

    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_valid = 1'b0; cfg_period = 12'd0; cfg_duty = 7'd0; run = 1'b0;
        step(); step();
        exp_v = {7'b0000000, 12'd0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_state: got flags=%b in=%0d want flags=%b in=%0d", obs[18:12], obs[11:0], exp_v[18:12], exp_v[11:0]); end
        rst = 1'b0;
        step();
        exp_v = {7'b1000000, 12'd0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_release_ready: got flags=%b in=%0d want flags=%b in=%0d", obs[18:12], obs[11:0], exp_v[18:12], exp_v[11:0]); end
    endtask

    task automatic test_out_en_unconfigured();
        run = 1'b1;
        step(); step();
        exp_v = {7'b1000000, 12'd0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL out_en_unconfigured: got flags=%b in=%0d want flags=%b in=%0d", obs[18:12], obs[11:0], exp_v[18:12], exp_v[11:0]); end
    endtask

    task automatic test_reject();
        logic [11:0] per [3];
        logic [6:0]  dut_y [3];
        per[0] = 12'd0;   dut_y[0] = 7'd50;
        per[1] = 12'd100; dut_y[1] = 7'd0;
        per[2] = 12'd100; dut_y[2] = 7'd100;
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b1; cfg_period = per[i]; cfg_duty = dut_y[i];
            step();
            cfg_valid = 1'b0;
            exp_v = {7'b1010000, 12'd0};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL reject_%0d_err: got flags=%b in=%0d want flags=%b in=%0d", i, obs[18:12], obs[11:0], exp_v[18:12], exp_v[11:0]); end
            step();
            exp_v = {7'b1000000, 12'd0};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL reject_%0d_after: got flags=%b in=%0d want flags=%b in=%0d", i, obs[18:12], obs[11:0], exp_v[18:12], exp_v[11:0]); end
        end
    endtask

`ifndef PWM_CFG_SOFT_RAMP_EN
    task automatic test_period_duty();
        cfg_valid = 1'b1; cfg_period = 12'd100; cfg_duty = 7'd25;
        step();
        cfg_valid = 1'b0; cfg_period = 12'd7; cfg_duty = 7'd3;
        exp_v = {7'b0001011, 12'd100};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL wr_period: got flags=%b in=%0d want flags=%b in=%0d", obs[18:12], obs[11:0], exp_v[18:12], exp_v[11:0]); end
        step();
        exp_v = {7'b0101001, 12'd25};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL wr_duty: got flags=%b in=%0d want flags=%b in=%0d", obs[18:12], obs[11:0], exp_v[18:12], exp_v[11:0]); end
        step();
        exp_v = {7'b1000100, 12'd25};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL back_to_idle: got flags=%b in=%0d want flags=%b in=%0d", obs[18:12], obs[11:0], exp_v[18:12], exp_v[11:0]); end
    endtask

    task automatic test_same_period();
        cfg_valid = 1'b1; cfg_period = 12'd100; cfg_duty = 7'd60;
        step();
        cfg_valid = 1'b0;
        exp_v = {7'b0101101, 12'd60};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL skip_period_duty: got flags=%b in=%0d want flags=%b in=%0d", obs[18:12], obs[11:0], exp_v[18:12], exp_v[11:0]); end
        step();
        exp_v = {7'b1000100, 12'd60};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL skip_period_idle: got flags=%b in=%0d want flags=%b in=%0d", obs[18:12], obs[11:0], exp_v[18:12], exp_v[11:0]); end
    endtask

    task automatic test_run_toggle();
        run = 1'b0;
        step();
        exp_v = {7'b1000000, 12'd60};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL run_off: got flags=%b in=%0d want flags=%b in=%0d", obs[18:12], obs[11:0], exp_v[18:12], exp_v[11:0]); end
        run = 1'b1;
        step();
        exp_v = {7'b1000100, 12'd60};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL run_on: got flags=%b in=%0d want flags=%b in=%0d", obs[18:12], obs[11:0], exp_v[18:12], exp_v[11:0]); end
    endtask
`else
    task automatic test_soft_ramp();
        logic        wr;
        logic [11:0] val;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        cfg_valid = 1'b1; cfg_period = 12'd200; cfg_duty = 7'd35;
        for (int k = 1; k <= 17; k++) begin
            step();
            // keep a different request pending for the whole ramp
            cfg_period = 12'd50; cfg_duty = 7'd50;
            wr  = (k == 1) || ((k >= 2) && ((k - 2) % 5 == 0));
            val = (k == 1) ? 12'd200 : 12'(((k - 2) / 5 + 1) * 10);
            if (val > 12'd35 && k != 1) val = 12'd35;
            exp_v = {1'b0, (k == 17), 1'b0, 1'b1, (k >= 3), (k == 1), wr, val};
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL ramp_cycle_%0d: got flags=%b in=%0d want flags=%b in=%0d", k, obs[18:12], obs[11:0], exp_v[18:12], exp_v[11:0]); end
        end
        cfg_valid = 1'b0;
        step();
        exp_v = {7'b1000100, 12'd35};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ramp_end_idle: got flags=%b in=%0d want flags=%b in=%0d", obs[18:12], obs[11:0], exp_v[18:12], exp_v[11:0]); end
    endtask
`endif

    task automatic test_reset_mid_sequence();
        cfg_valid = 1'b1; cfg_period = 12'd300; cfg_duty = 7'd40;
        step();
        cfg_valid = 1'b0;
        exp_v = {7'b0001111, 12'd300};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL midrst_wr_period: got flags=%b in=%0d want flags=%b in=%0d", obs[18:12], obs[11:0], exp_v[18:12], exp_v[11:0]); end
        rst = 1'b1;
        step();
        exp_v = {7'b0000000, 12'd0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL midrst_cleared: got flags=%b in=%0d want flags=%b in=%0d", obs[18:12], obs[11:0], exp_v[18:12], exp_v[11:0]); end
        rst = 1'b0;
        step();
        exp_v = {7'b1000000, 12'd0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL midrst_no_duty_write: got flags=%b in=%0d want flags=%b in=%0d", obs[18:12], obs[11:0], exp_v[18:12], exp_v[11:0]); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_out_en_unconfigured();
        test_reject();
`ifndef PWM_CFG_SOFT_RAMP_EN
        test_period_duty();
        test_same_period();
        test_run_toggle();
`else
        test_soft_ramp();
`endif
        test_reset_mid_sequence();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
